// File: rtl/tempsens_pkg.sv
// Shared defaults and FSM state type for the temperature-sensor averaging block.
package tempsens_pkg;

  localparam int unsigned DW_DEF    = 12;
  localparam int unsigned LOG2N_DEF = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/tempsens_minmax.sv
// Running minimum/maximum of every value loaded into the averager's output register.
module tempsens_minmax
  import tempsens_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_ld,
  input  logic [DW-1:0] i_dat,
  output logic [DW-1:0] o_min,
  output logic [DW-1:0] o_max
);

  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (i_clr) begin
      min_d = '1;
      max_d = '0;
    end else if (i_ld) begin
      if (i_dat < min_q) min_d = i_dat;
      if (i_dat > max_q) max_d = i_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign o_min = min_q;
  assign o_max = max_q;

endmodule

// File: rtl/tempsens_avg.sv
// Averages each group of 2^LOG2N raw sensor samples into a held, handshaked result
// with sticky drop flag and min/max statistics of delivered results.
module tempsens_avg
  import tempsens_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned LOG2N = LOG2N_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic [DW-1:0] i_raw_dat,
  input  logic          i_raw_vld,
  output logic [DW-1:0] o_avg_dat,
  output logic          o_avg_vld,
  input  logic          i_avg_rdy,
  output logic [DW-1:0] o_min,
  output logic [DW-1:0] o_max,
  output logic          o_ovf,
  output logic          o_busy
);

  localparam int unsigned AW = DW + LOG2N;
  localparam int unsigned CW = LOG2N + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2N) - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] avg_dat_q, avg_dat_d;
  logic          avg_vld_q, avg_vld_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          ld_q, ld_d;
  logic [AW-1:0] sum_c;
  logic          complete_c;
  logic          xfer_c;

  // Next-state, accumulation and output-register policy.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    avg_dat_d  = avg_dat_q;
    avg_vld_d  = avg_vld_q;
    ovf_d      = ovf_q;
    ld_d       = 1'b0;
    complete_c = 1'b0;
    xfer_c     = avg_vld_q & i_avg_rdy;
    sum_c      = (state_q == ST_ACC) ? (acc_q + AW'(i_raw_dat)) : AW'(i_raw_dat);

    if (i_clr) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      cnt_d     = '0;
      avg_vld_d = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      if (i_raw_vld) begin
        case (state_q)
          ST_IDLE: begin
            if (LOG2N == 0) begin
              complete_c = 1'b1;
            end else begin
              acc_d   = sum_c;
              cnt_d   = CW'(1);
              state_d = ST_ACC;
            end
          end
          ST_ACC: begin
            if (cnt_q == CNT_LAST) begin
              complete_c = 1'b1;
              acc_d      = '0;
              cnt_d      = '0;
              state_d    = ST_IDLE;
            end else begin
              acc_d = sum_c;
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      // A result can only land when the output register is free or draining this cycle.
      if (complete_c && (!avg_vld_q || i_avg_rdy)) begin
        avg_dat_d = DW'(sum_c >> LOG2N);
        avg_vld_d = 1'b1;
        ld_d      = 1'b1;
      end else begin
        if (complete_c) ovf_d = 1'b1;
        if (xfer_c) avg_vld_d = 1'b0;
      end
    end

    busy_d = (state_d == ST_ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_dat_q <= '0;
      avg_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_dat_q <= avg_dat_d;
      avg_vld_q <= avg_vld_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      ld_q      <= ld_d;
    end
  end

  // Statistics follow the output register by one edge.
  tempsens_minmax #(
    .DW (DW)
  ) u_minmax (
    .clk   (clk),
    .rst   (rst),
    .i_clr (i_clr),
    .i_ld  (ld_q),
    .i_dat (avg_dat_q),
    .o_min (o_min),
    .o_max (o_max)
  );

  assign o_avg_dat = avg_dat_q;
  assign o_avg_vld = avg_vld_q;
  assign o_ovf     = ovf_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_tempsens_avg.sv
// Bench for tempsens_avg: directed scenarios plus randomized traffic against a queue-based model.
module tb_tempsens_avg;

  localparam int DW = 12;
  localparam int N  = 4;

  logic          clk;
  logic          rst;
  logic          i_clr;
  logic [DW-1:0] i_raw_dat;
  logic          i_raw_vld;
  logic [DW-1:0] o_avg_dat;
  logic          o_avg_vld;
  logic          i_avg_rdy;
  logic [DW-1:0] o_min;
  logic [DW-1:0] o_max;
  logic          o_ovf;
  logic          o_busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int   q_smp[$];
  int   m_dat, m_min, m_max;
  logic m_vld, m_ovf, m_busy, m_ld_prev;

  tempsens_avg #(.DW(DW), .LOG2N(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (i_clr),
    .i_raw_dat (i_raw_dat),
    .i_raw_vld (i_raw_vld),
    .o_avg_dat (o_avg_dat),
    .o_avg_vld (o_avg_vld),
    .i_avg_rdy (i_avg_rdy),
    .o_min     (o_min),
    .o_max     (o_max),
    .o_ovf     (o_ovf),
    .o_busy    (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance the model at the rising edge, settle #1 after it.
  task automatic step(input logic r, input logic c, input logic v, input int d, input logic y);
    int  sum;
    int  avg;
    logic complete, load, xfer;
    @(negedge clk);
    rst = r; i_clr = c; i_raw_vld = v; i_raw_dat = DW'(d); i_avg_rdy = y;
    @(posedge clk);
    if (r) begin
      q_smp.delete();
      m_dat = 0; m_vld = 0; m_ovf = 0; m_min = 4095; m_max = 0; m_ld_prev = 0;
    end else if (c) begin
      q_smp.delete();
      m_vld = 0; m_ovf = 0; m_min = 4095; m_max = 0; m_ld_prev = 0;
    end else begin
      if (m_ld_prev) begin
        if (m_dat < m_min) m_min = m_dat;
        if (m_dat > m_max) m_max = m_dat;
      end
      xfer = m_vld && y;
      complete = 0;
      avg = 0;
      if (v) begin
        q_smp.push_back(d);
        if (q_smp.size() == N) begin
          sum = 0;
          foreach (q_smp[k]) sum += q_smp[k];
          avg = sum / N;
          q_smp.delete();
          complete = 1;
        end
      end
      load = complete && (!m_vld || y);
      if (load) begin
        m_dat = avg; m_vld = 1;
      end else begin
        if (complete) m_ovf = 1;
        if (xfer) m_vld = 0;
      end
      m_ld_prev = load;
    end
    m_busy = (q_smp.size() > 0);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 77, 0);
    total++; if (o_avg_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0d exp=0", o_avg_vld); end
    total++; if (o_avg_dat !== 12'd0) begin bad++; $display("FAIL reset_dat got=%0d exp=0", o_avg_dat); end
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", o_ovf); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0d exp=0", o_busy); end
    total++; if (o_min !== 12'hfff) begin bad++; $display("FAIL reset_min got=%0d exp=4095", o_min); end
    total++; if (o_max !== 12'd0) begin bad++; $display("FAIL reset_max got=%0d exp=0", o_max); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 100 + i, 0);
      total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL basic_busy%0d got=%0d exp=1", i, o_busy); end
    end
    step(0, 0, 1, 103, 0);
    total++; if (o_avg_dat !== 12'd101) begin bad++; $display("FAIL basic_dat got=%0d exp=101", o_avg_dat); end
    total++; if (o_avg_vld !== 1'b1) begin bad++; $display("FAIL basic_vld got=%0d exp=1", o_avg_vld); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0d exp=0", o_busy); end
    step(0, 0, 0, 0, 0);
    total++; if (o_avg_vld !== 1'b1) begin bad++; $display("FAIL basic_hold got=%0d exp=1", o_avg_vld); end
    step(0, 0, 0, 0, 1);
    total++; if (o_avg_vld !== 1'b0) begin bad++; $display("FAIL basic_drain got=%0d exp=0", o_avg_vld); end
    total++; if (o_min !== 12'd101 || o_max !== 12'd101) begin bad++; $display("FAIL basic_minmax got=%0d/%0d exp=101/101", o_min, o_max); end
  endtask

  task automatic test_full_scale();
    for (int i = 0; i < N; i++) step(0, 0, 1, 4095, 1);
    total++; if (o_avg_dat !== 12'd4095) begin bad++; $display("FAIL full_dat got=%0d exp=4095", o_avg_dat); end
    total++; if (o_max !== 12'd101) begin bad++; $display("FAIL full_max_early got=%0d exp=101", o_max); end
    step(0, 0, 0, 0, 1);
    total++; if (o_max !== 12'd4095) begin bad++; $display("FAIL full_max got=%0d exp=4095", o_max); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 200, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 300, 0);
      total++; if (o_avg_dat !== 12'd200) begin bad++; $display("FAIL ovf_hold%0d got=%0d exp=200", i, o_avg_dat); end
    end
    total++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", o_ovf); end
    total++; if (o_avg_vld !== 1'b1) begin bad++; $display("FAIL ovf_vld got=%0d exp=1", o_avg_vld); end
    step(0, 1, 0, 0, 0);
    total++; if (o_ovf !== 1'b0 || o_avg_vld !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0d/%0d exp=0/0", o_ovf, o_avg_vld); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N; i++) step(0, 0, 1, 10, 0);
    total++; if (o_avg_dat !== 12'd10 || o_avg_vld !== 1'b1) begin bad++; $display("FAIL b2b_first got=%0d/%0d exp=10/1", o_avg_dat, o_avg_vld); end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 20, 0);
    step(0, 0, 1, 20, 1);
    total++; if (o_avg_dat !== 12'd20) begin bad++; $display("FAIL b2b_dat got=%0d exp=20", o_avg_dat); end
    total++; if (o_avg_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld got=%0d exp=1", o_avg_vld); end
    total++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL b2b_ovf got=%0d exp=0", o_ovf); end
  endtask

  task automatic test_clr_priority();
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 50, 1);
    step(0, 0, 1, 50, 1);
    step(0, 1, 1, 50, 1);
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL clr_busy got=%0d exp=0", o_busy); end
    for (int i = 0; i < N; i++) step(0, 0, 1, 8, 0);
    total++; if (o_avg_dat !== 12'd8 || o_avg_vld !== 1'b1) begin bad++; $display("FAIL clr_dat got=%0d/%0d exp=8/1", o_avg_dat, o_avg_vld); end
    step(0, 0, 0, 0, 1);
    total++; if (o_min !== 12'd8) begin bad++; $display("FAIL clr_min got=%0d exp=8", o_min); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1000, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 1, 16, 1);
    total++; if (o_avg_dat !== 12'd16) begin bad++; $display("FAIL rstmid_dat got=%0d exp=16", o_avg_dat); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0d exp=0", o_busy); end
  endtask

  task automatic test_random();
    logic r, c, v, y;
    int d;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 2) != 0);
      y = ($urandom_range(0, 3) != 0);
      d = (n % 5 == 0) ? 4095 : int'($urandom_range(0, 4095));
      step(r, c, v, d, y);
      total++; if (o_avg_vld !== m_vld) begin bad++; $display("FAIL rnd_vld n=%0d got=%0d exp=%0d", n, o_avg_vld, m_vld); end
      total++; if (o_avg_dat !== DW'(m_dat)) begin bad++; $display("FAIL rnd_dat n=%0d got=%0d exp=%0d", n, o_avg_dat, m_dat); end
      total++; if (o_ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%0d exp=%0d", n, o_ovf, m_ovf); end
      total++; if (o_busy !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%0d exp=%0d", n, o_busy, m_busy); end
      total++; if (o_min !== DW'(m_min)) begin bad++; $display("FAIL rnd_min n=%0d got=%0d exp=%0d", n, o_min, m_min); end
      total++; if (o_max !== DW'(m_max)) begin bad++; $display("FAIL rnd_max n=%0d got=%0d exp=%0d", n, o_max, m_max); end
    end
  endtask

  initial begin
    rst = 1'b1; i_clr = 1'b0; i_raw_vld = 1'b0; i_raw_dat = '0; i_avg_rdy = 1'b0;
    test_reset();
    test_basic();
    test_full_scale();
    test_overflow();
    test_back_to_back();
    test_clr_priority();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
